instr_fetch: RTL
================

// Module: instr_fetch
//
// PURPOSE
// Program-counter and instruction-fetch stage of the 9-bit single-cycle core.
// Drives the instruction-ROM address, computes next PC (sequential, LUT-based
// absolute jump, or LUT-based relative branch), and detects the halt word.
// Raises the core's Done flag. Feeds the decode/control stage and
// register file downstream; branch decisions come back from control/ALU.
//
// PARAMETERS
// PC_W       10            program counter width (ROM depth 2**PC_W)
// INSTR_W    9             instruction width
// LUT_IDX_W  4             branch-target LUT index width (16 entries)
// HALT_CODE  9'b011111111  instruction word that stops the machine
// CNT_W      16            retired-instruction counter width
//
// PORTS
// Clk        in   1          core clock, all state updates on posedge
// Reset      in   1          synchronous, active-high
// Stall      in   1          hold PC and all state this cycle
// BranchEn   in   1          control: branch/jump taken for current instr
// Absolute   in   1          1: PC <= LUT[idx]; 0: PC <= PC + LUT[idx] (signed)
// TargetIdx  in   LUT_IDX_W  LUT index supplied by decode
// InstrIn    in   INSTR_W    ROM data at ProgCounter (combinational read)
// LutWe      in   1          LUT write enable (bench/boot load)
// LutAddr    in   LUT_IDX_W  LUT write index
// LutData    in   PC_W       LUT write data
// ProgCounter out PC_W       current PC, ROM address
// Instr      out  INSTR_W    InstrIn passed to decode; forced to 0 when Done
// Done       out  1          high from cycle after halt fetch until Reset
// RetiredCnt out  CNT_W      instructions completed since Reset
//
// BEHAVIOUR
// - States: RUN, HALT. Reset (sync, overrides all inputs): state=RUN,
//   ProgCounter=0, Done=0, RetiredCnt=0. LUT is NOT cleared by Reset.
// - Reset asserted mid-program: next posedge gives PC=0, Done=0, cnt=0.
// - RUN, Stall=1: PC, state, counter hold; halt detection suppressed.
// - RUN, Stall=0, priority order at posedge:
//   1. InstrIn==HALT_CODE -> state=HALT, Done=1, PC holds; cnt not incr.
//   2. BranchEn&Absolute   -> PC <= LUT[TargetIdx].
//   3. BranchEn&!Absolute  -> PC <= PC + LUT[TargetIdx] (two's complement,
//      mod 2**PC_W).
//   4. else                -> PC <= PC+1 (wraps 2**PC_W-1 -> 0).
//   Cases 2-4 increment RetiredCnt (saturates at all-ones, no wrap).
// - HALT: PC, cnt, Done hold; Stall/BranchEn ignored; exit only via Reset.
// - Halt word with BranchEn=1 same cycle: halt wins, no jump.
// - LUT: sync write on posedge when LutWe; a read of the same index in the
//   same cycle sees the OLD value (write-before-read not allowed).
//   LutWe accepted in any state, including HALT and during Reset.
// - Latency: one cycle from posedge to new PC; Instr combinational from
//   InstrIn (zero latency); Done one cycle after halt word is on InstrIn.
//
// TESTING
// 1. Reset 2 cycles, ROM = 3 NOPs + HALT at 3 -> PC 0,1,2,3; Done=1 at
//    cycle after PC=3; RetiredCnt=3; PC stays 3 for 10 more cycles.
// 2. LUT[5]=10'd40, PC=7, BranchEn=1,Absolute=1,TargetIdx=5 -> PC=40 next
//    cycle; LUT[2]=10'h3FE (-2), Absolute=0 at PC=40 -> PC=38.
// 3. Stall=1 for 3 cycles at PC=12 with HALT_CODE on InstrIn -> PC=12,
//    Done=0 throughout; Stall drops -> Done=1 next cycle.
// 4. PC=1023, no branch -> PC=0; relative +5 at PC=1021 -> PC=2.
// 5. HALT_CODE and BranchEn=1 same cycle -> Done=1, PC unchanged; Reset
//    during HALT -> PC=0, Done=0, RetiredCnt=0, LUT contents intact.
// 6. LutWe writes LUT[3]=99 while branching via idx 3 (old=20) -> PC=20;
//    branch via idx 3 next cycle -> PC=99.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage port bundle between the fetch stage and its control/ROM side.
// The slave modport is the fetch stage; the master modport is the control side.
interface instr_fetch_if #(
    parameter int PC_W      = 10,
    parameter int INSTR_W   = 9,
    parameter int LUT_IDX_W = 4,
    parameter int CNT_W     = 16
);
    logic                 Stall;
    logic                 BranchEn;
    logic                 Absolute;
    logic [LUT_IDX_W-1:0] TargetIdx;
    logic [INSTR_W-1:0]   InstrIn;
    logic                 LutWe;
    logic [LUT_IDX_W-1:0] LutAddr;
    logic [PC_W-1:0]      LutData;
    logic [PC_W-1:0]      ProgCounter;
    logic [INSTR_W-1:0]   Instr;
    logic                 Done;
    logic [CNT_W-1:0]     RetiredCnt;

    modport slave (
        input  Stall, BranchEn, Absolute, TargetIdx, InstrIn,
        input  LutWe, LutAddr, LutData,
        output ProgCounter, Instr, Done, RetiredCnt
    );

    modport master (
        output Stall, BranchEn, Absolute, TargetIdx, InstrIn,
        output LutWe, LutAddr, LutData,
        input  ProgCounter, Instr, Done, RetiredCnt
    );
endinterface

// File: rtl/instr_fetch.sv
// Program counter and instruction fetch for the 9-bit core: sequential,
// LUT-absolute and LUT-relative next-PC, halt detection and retired count.
module instr_fetch #(
    parameter int                 PC_W      = 10,
    parameter int                 INSTR_W   = 9,
    parameter int                 LUT_IDX_W = 4,
    parameter logic [INSTR_W-1:0] HALT_CODE = 9'b011111111,
    parameter int                 CNT_W     = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    instr_fetch_if.slave  bus
);
    typedef enum logic {ST_RUN, ST_HALT} state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  lut_q [2**LUT_IDX_W];
    logic [PC_W-1:0]  lut_rd;
    logic             done;

    // Reads return the value held before any write landing on this same edge.
    assign lut_rd = lut_q[bus.TargetIdx];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (state_q == ST_RUN && !bus.Stall) begin
            if (bus.InstrIn == HALT_CODE) begin
                state_d = ST_HALT;
            end else begin
                if (bus.BranchEn && bus.Absolute) begin
                    pc_d = lut_rd;
                end else if (bus.BranchEn) begin
                    pc_d = pc_q + lut_rd;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the target LUT is deliberately left out of reset so boot-loaded entries survive it.
    always_ff @(posedge Clk) begin
        if (bus.LutWe) begin
            lut_q[bus.LutAddr] <= bus.LutData;
        end
    end

    assign done            = (state_q == ST_HALT);
    assign bus.Done        = done;
    assign bus.ProgCounter = pc_q;
    assign bus.RetiredCnt  = cnt_q;
    assign bus.Instr       = done ? '0 : bus.InstrIn;
endmodule
